// File: rtl/uart_rx_byte.sv
// UART byte receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Good bytes leave as a one-cycle write strobe with dataout; bad stop bits pulse frame_err.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic       write,
  output logic [7:0] dataout,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  localparam logic [CNT_W-1:0] HalfM1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FullM1 = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dataout_q, dataout_d;
  logic             write_q, write_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_meta_q, rxs_q;
  logic             par_ok;

`ifdef UART_RX_PARITY_EN
  logic parity_q, parity_d;
  logic parity_err_q, parity_err_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      dataout_q   <= '0;
      write_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      dataout_q   <= dataout_d;
      write_q     <= write_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_q     <= parity_d;
      parity_err_q <= parity_err_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    dataout_d   = dataout_q;
    write_d     = 1'b0;
    frame_err_d = 1'b0;
    par_ok      = 1'b1;
`ifdef UART_RX_PARITY_EN
    parity_d     = parity_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (en && !rxs_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d   = '0;
          state_d = rxs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == FullM1) begin
          cnt_d    = '0;
          parity_d = rxs_q;
          state_d  = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == FullM1) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          // Even parity: parity bit equals XOR of the data bits.
          par_ok       = (parity_q == ^shift_q);
          parity_err_d = !par_ok;
`endif
          if (rxs_q) begin
            state_d = StIdle;
            if (par_ok) begin
              write_d   = 1'b1;
              dataout_d = shift_q;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // Hold here until the line idles so a stuck-low line cannot retrigger.
        cnt_d = '0;
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign write     = write_q;
  assign dataout   = dataout_q;
  assign busy      = (state_q != StIdle);
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte with CLKS_PER_BIT=16; define UART_RX_PARITY_EN for 8E1.
module tb_uart_rx_byte;

  localparam int Cpb = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       rx  = 1'b1;
  logic       write;
  logic [7:0] dataout;
  logic       busy;
  logic       frame_err;
  logic       parity_err;

  int n_vec = 0;
  int n_err = 0;

  int         wr_cnt = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         busy_cnt = 0;
  int         overlap = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;

  uart_rx_byte #(
    .CLKS_PER_BIT(Cpb),
    .CNT_W       (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rx        (rx),
    .write     (write),
    .dataout   (dataout),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write) begin
      wr_cnt    <= wr_cnt + 1;
      last_data <= dataout;
      prev_data <= last_data;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (write && (frame_err || parity_err)) overlap <= overlap + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    wait_cycles(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(Cpb);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^d;
    wait_cycles(Cpb);
`endif
    rx = stop_bit;
    wait_cycles(Cpb - 1);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_bit);
    @(negedge clk);
    rx = 1'b0;
    wait_cycles(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(Cpb);
    end
    rx = par_bit;
    wait_cycles(Cpb);
    rx = 1'b1;
    wait_cycles(Cpb - 1);
  endtask
`endif

  task automatic test_reset;
    wait_cycles(3);
    n_vec++; if (write !== 1'b0) begin n_err++; $display("FAIL rst_write got %b want 0", write); end
    n_vec++; if (dataout !== 8'h00) begin n_err++; $display("FAIL rst_data got %h want 00", dataout); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_ferr got %b want 0", frame_err); end
    n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL rst_perr got %b want 0", parity_err); end
    rst = 1'b0;
    en  = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_basic;
    int w0 = wr_cnt;
    int f0 = fe_cnt;
    int b0 = busy_cnt;
    send_frame(8'hA5, 1'b1);
    wait_cycles(4);
    n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL basic_wr got %0d want 1", wr_cnt - w0); end
    n_vec++; if (dataout !== 8'hA5) begin n_err++; $display("FAIL basic_data got %h want a5", dataout); end
    n_vec++; if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL basic_ferr got %0d want 0", fe_cnt - f0); end
    n_vec++; if (busy_cnt - b0 < 9 * Cpb) begin n_err++; $display("FAIL basic_busy_cyc got %0d want >=%0d", busy_cnt - b0, 9 * Cpb); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end got %b want 0", busy); end
  endtask

  task automatic test_false_start;
    int w0 = wr_cnt;
    int f0 = fe_cnt;
    int b0 = busy_cnt;
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(12);
    n_vec++; if (busy_cnt - b0 < 1) begin n_err++; $display("FAIL fs_entered got %0d want >0", busy_cnt - b0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fs_busy got %b want 0", busy); end
    n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL fs_wr got %0d want 0", wr_cnt - w0); end
    n_vec++; if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL fs_ferr got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_frame_error;
    int w0 = wr_cnt;
    int f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    wait_cycles(24);
    n_vec++; if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL fe_pulse got %0d want 1", fe_cnt - f0); end
    n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL fe_wr got %0d want 0", wr_cnt - w0); end
    n_vec++; if (dataout !== 8'hA5) begin n_err++; $display("FAIL fe_data got %h want a5", dataout); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL fe_break_busy got %b want 1", busy); end
    rx = 1'b1;
    wait_cycles(6);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fe_idle got %b want 0", busy); end
    w0 = wr_cnt;
    send_frame(8'h11, 1'b1);
    wait_cycles(4);
    n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL fe_next_wr got %0d want 1", wr_cnt - w0); end
    n_vec++; if (dataout !== 8'h11) begin n_err++; $display("FAIL fe_next_data got %h want 11", dataout); end
  endtask

  task automatic test_back_to_back;
    int w0 = wr_cnt;
    int f0 = fe_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cycles(4);
    n_vec++; if (wr_cnt - w0 !== 2) begin n_err++; $display("FAIL b2b_wr got %0d want 2", wr_cnt - w0); end
    n_vec++; if (prev_data !== 8'h00) begin n_err++; $display("FAIL b2b_first got %h want 00", prev_data); end
    n_vec++; if (last_data !== 8'hFF) begin n_err++; $display("FAIL b2b_second got %h want ff", last_data); end
    n_vec++; if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL b2b_ferr got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_reset_mid;
    int w0;
    @(negedge clk);
    rx = 1'b0;
    wait_cycles(Cpb);
    rx = 1'b0;
    wait_cycles(Cpb);
    rx = 1'b1;
    wait_cycles(Cpb);
    rx = 1'b0;
    wait_cycles(8);
    rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got %b want 0", busy); end
    n_vec++; if (dataout !== 8'h00) begin n_err++; $display("FAIL rm_data got %h want 00", dataout); end
    n_vec++; if (write !== 1'b0) begin n_err++; $display("FAIL rm_write got %b want 0", write); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rm_ferr got %b want 0", frame_err); end
    rx = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(4);
    w0 = wr_cnt;
    send_frame(8'hC3, 1'b1);
    wait_cycles(4);
    n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL rm_wr got %0d want 1", wr_cnt - w0); end
    n_vec++; if (dataout !== 8'hC3) begin n_err++; $display("FAIL rm_c3 got %h want c3", dataout); end
  endtask

  task automatic test_enable;
    int w0 = wr_cnt;
    int b0 = busy_cnt;
    en = 1'b0;
    send_frame(8'h77, 1'b1);
    wait_cycles(4);
    n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL en0_wr got %0d want 0", wr_cnt - w0); end
    n_vec++; if (busy_cnt - b0 !== 0) begin n_err++; $display("FAIL en0_busy got %0d want 0", busy_cnt - b0); end
    n_vec++; if (dataout !== 8'hC3) begin n_err++; $display("FAIL en0_data got %h want c3", dataout); end
    en = 1'b1;
    wait_cycles(2);
    w0 = wr_cnt;
    fork
      send_frame(8'h77, 1'b1);
      begin
        wait_cycles(40);
        en = 1'b0;
        wait_cycles(60);
        en = 1'b1;
      end
    join
    wait_cycles(4);
    n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL en_mid_wr got %0d want 1", wr_cnt - w0); end
    n_vec++; if (dataout !== 8'h77) begin n_err++; $display("FAIL en_mid_data got %h want 77", dataout); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int w0 = wr_cnt;
    int p0 = pe_cnt;
    send_frame_par(8'h07, 1'b0);
    wait_cycles(4);
    n_vec++; if (pe_cnt - p0 !== 1) begin n_err++; $display("FAIL par_bad_perr got %0d want 1", pe_cnt - p0); end
    n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL par_bad_wr got %0d want 0", wr_cnt - w0); end
    w0 = wr_cnt;
    p0 = pe_cnt;
    send_frame_par(8'h07, 1'b1);
    wait_cycles(4);
    n_vec++; if (pe_cnt - p0 !== 0) begin n_err++; $display("FAIL par_ok_perr got %0d want 0", pe_cnt - p0); end
    n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL par_ok_wr got %0d want 1", wr_cnt - w0); end
    n_vec++; if (dataout !== 8'h07) begin n_err++; $display("FAIL par_ok_data got %h want 07", dataout); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_reset_mid();
    test_enable();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    n_vec++; if (pe_cnt !== 0) begin n_err++; $display("FAIL perr_tied got %0d want 0", pe_cnt); end
`endif
    n_vec++; if (overlap !== 0) begin n_err++; $display("FAIL overlap got %0d want 0", overlap); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
